// File: rtl/gpio_dbirq.sv
// N-pin GPIO on the register mesh: pad out/enable, synchronised and optionally
// debounced inputs, level/edge/both-edge interrupt latch with W1S/W1C and mask.
module gpio_dbirq #(
    parameter int N    = 32,
    parameter int AW   = 32,
    parameter int PW   = 2*AW+40,
    parameter int ID   = 0,
    parameter int CW   = 8,
    parameter int DIVW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reg_access,
    input  logic [PW-1:0] reg_packet,
    output logic [31:0]   reg_rdata,
    input  logic [N-1:0]  gpio_in,
    output logic [N-1:0]  gpio_out,
    output logic [N-1:0]  gpio_en,
    output logic [N-1:0]  gpio_ilat,
    output logic          gpio_irq
);

    localparam logic [5:0] W_ODATA    = 6'd0;
    localparam logic [5:0] W_OEN      = 6'd1;
    localparam logic [5:0] W_IDATA    = 6'd2;
    localparam logic [5:0] W_ITYPE    = 6'd3;
    localparam logic [5:0] W_IPOL     = 6'd4;
    localparam logic [5:0] W_IMASK    = 6'd5;
    localparam logic [5:0] W_ILAT     = 6'd6;
    localparam logic [5:0] W_ILATCLR  = 6'd7;
    localparam logic [5:0] W_ODATAAND = 6'd8;
    localparam logic [5:0] W_ODATAORR = 6'd9;
    localparam logic [5:0] W_ODATAXOR = 6'd10;
    localparam logic [5:0] W_IBOTH    = 6'd11;
    localparam logic [5:0] W_DBEN     = 6'd12;
    localparam logic [5:0] W_DBDIV    = 6'd13;
    localparam logic [5:0] W_DBTHR    = 6'd14;

    // Packet fields: write bit 0, dstaddr at [AW+7:8], data at [AW+39:AW+8].
    logic            write_in;
    logic            match;
    logic            wr;
    logic [5:0]      word;
    logic [N-1:0]    dn;
    logic [DIVW-1:0] d_div;
    logic [CW-1:0]   d_thr;
    logic            unused_pkt;

    assign write_in   = reg_packet[0];
    assign match      = reg_access & (reg_packet[18:16] == 3'(ID));
    assign word       = reg_packet[15:10];
    assign wr         = match & write_in;
    assign dn         = reg_packet[AW+8+N-1:AW+8];
    assign d_div      = reg_packet[AW+8+DIVW-1:AW+8];
    assign d_thr      = reg_packet[AW+8+CW-1:AW+8];
    assign unused_pkt = ^reg_packet;

    logic [N-1:0]    odata, oen, itype, ipol, iboth, imask, ilat, dben;
    logic [DIVW-1:0] dbdiv;
    logic [CW-1:0]   dbthr;

    always_ff @(posedge clk) begin
        if (reset) begin
            odata <= '0;
            oen   <= '0;
            itype <= '0;
            ipol  <= '0;
            iboth <= '0;
            imask <= '0;
            dben  <= '0;
            dbdiv <= '0;
            dbthr <= '0;
        end else if (wr) begin
            case (word)
                W_ODATA:    odata <= dn;
                W_OEN:      oen   <= dn;
                W_ITYPE:    itype <= dn;
                W_IPOL:     ipol  <= dn;
                W_IMASK:    imask <= dn;
                W_ODATAAND: odata <= odata & dn;
                W_ODATAORR: odata <= odata | dn;
                W_ODATAXOR: odata <= odata ^ dn;
                W_IBOTH:    iboth <= dn;
                W_DBEN:     dben  <= dn;
                W_DBDIV:    dbdiv <= d_div;
                W_DBTHR:    dbthr <= d_thr;
                default:    ;
            endcase
        end
    end

    // Input path: 2-flop synchroniser, then per-pin filter.
    logic [N-1:0]    sync1, sync2, filt_q, prev_q;
    logic [DIVW-1:0] div_cnt;
    logic [CW-1:0]   db_cnt [N];
    logic            tick;
    logic [CW-1:0]   thr_eff;
    logic [N-1:0]    db_hit;

    assign tick    = (div_cnt >= dbdiv);
    assign thr_eff = (dbthr == '0) ? CW'(1) : dbthr;

    always_comb begin
        db_hit = '0;
        for (int i = 0; i < N; i++) begin
            db_hit[i] = (({1'b0, db_cnt[i]} + (CW+1)'(1)) >= {1'b0, thr_eff});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            filt_q  <= '0;
            prev_q  <= '0;
            div_cnt <= '0;
            for (int i = 0; i < N; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= gpio_in;
            sync2   <= sync1;
            prev_q  <= filt_q;
            div_cnt <= tick ? '0 : div_cnt + DIVW'(1);
            for (int i = 0; i < N; i++) begin
                if (!dben[i]) begin
                    filt_q[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else if (sync2[i] == filt_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    if (db_hit[i]) begin
                        filt_q[i] <= ~filt_q[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Interrupt events and latch; a set always wins over a same-cycle clear.
    logic [N-1:0] rise, fall, edge_ev, event_v, set_w, clr_w, ilat_next;

    always_comb begin
        rise      = filt_q & ~prev_q;
        fall      = ~filt_q & prev_q;
        edge_ev   = (iboth & (rise | fall)) | (~iboth & ((ipol & fall) | (~ipol & rise)));
        event_v   = (itype & edge_ev) | (~itype & (filt_q ^ ipol));
        set_w     = (wr && word == W_ILAT)    ? dn : '0;
        clr_w     = (wr && word == W_ILATCLR) ? dn : '0;
        ilat_next = event_v | set_w | (ilat & ~clr_w);
    end

    always_ff @(posedge clk) begin
        if (reset) ilat <= '0;
        else       ilat <= ilat_next;
    end

    logic [31:0] rdata_mux;

    always_comb begin
        rdata_mux = '0;
        case (word)
            W_ODATA:   rdata_mux = 32'(odata);
            W_OEN:     rdata_mux = 32'(oen);
            W_IDATA:   rdata_mux = 32'(filt_q);
            W_ITYPE:   rdata_mux = 32'(itype);
            W_IPOL:    rdata_mux = 32'(ipol);
            W_IMASK:   rdata_mux = 32'(imask);
            W_ILAT:    rdata_mux = 32'(ilat);
            W_ILATCLR: rdata_mux = 32'(ilat);
            W_IBOTH:   rdata_mux = 32'(iboth);
            W_DBEN:    rdata_mux = 32'(dben);
            W_DBDIV:   rdata_mux = 32'(dbdiv);
            W_DBTHR:   rdata_mux = 32'(dbthr);
            default:   rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                   reg_rdata <= '0;
        else if (match && !write_in) reg_rdata <= rdata_mux;
    end

    assign gpio_out  = odata;
    assign gpio_en   = oen;
    assign gpio_ilat = ilat;
    assign gpio_irq  = |(ilat & imask);

endmodule

// File: tb/tb_gpio_dbirq.sv
// Bench for gpio_dbirq: a 32-pin instance and an 8-pin instance on one shared
// register bus with different block ids.
module tb_gpio_dbirq;
    localparam int AW = 32;
    localparam int PW = 2*AW+40;
    localparam logic [2:0] ID_M = 3'd3;
    localparam logic [2:0] ID_S = 3'd1;

    logic          clk = 1'b0;
    logic          reset;
    logic          reg_access;
    logic [PW-1:0] reg_packet;
    logic [31:0]   gpio_in;
    logic [31:0]   rdata_m, rdata_s;
    logic [31:0]   gpio_out_m, gpio_en_m, ilat_m;
    logic [7:0]    gpio_out_s, gpio_en_s, ilat_s;
    logic          irq_m, irq_s;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_odata;

    always #5 clk = ~clk;

    gpio_dbirq #(.N(32), .ID(3)) dut_m (
        .clk(clk), .reset(reset), .reg_access(reg_access), .reg_packet(reg_packet),
        .reg_rdata(rdata_m), .gpio_in(gpio_in), .gpio_out(gpio_out_m),
        .gpio_en(gpio_en_m), .gpio_ilat(ilat_m), .gpio_irq(irq_m)
    );

    gpio_dbirq #(.N(8), .ID(1)) dut_s (
        .clk(clk), .reset(reset), .reg_access(reg_access), .reg_packet(reg_packet),
        .reg_rdata(rdata_s), .gpio_in(gpio_in[7:0]), .gpio_out(gpio_out_s),
        .gpio_en(gpio_en_s), .gpio_ilat(ilat_s), .gpio_irq(irq_s)
    );

    // ---------------- driver tasks (called on a negedge, return on a negedge)
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic w, input logic [2:0] id, input logic [5:0] word,
                        input logic [31:0] data);
        reg_packet = '0;
        reg_packet[0] = w;
        reg_packet[18:16] = id;
        reg_packet[15:10] = word;
        reg_packet[AW+39:AW+8] = data;
        reg_access = 1'b1;
        @(negedge clk);
        reg_access = 1'b0;
        reg_packet = '0;
    endtask

    task automatic wr(input logic [2:0] id, input logic [5:0] word, input logic [31:0] data);
        send(1'b1, id, word, data);
    endtask

    task automatic rd(input logic [2:0] id, input logic [5:0] word,
                      output logic [31:0] dm, output logic [31:0] ds);
        send(1'b0, id, word, 32'h0);
        dm = rdata_m;
        ds = rdata_s;
    endtask

    task automatic setup_edge();
        wr(ID_M, 6'd3, 32'hFFFF_FFFF);
        wr(ID_M, 6'd4, 32'h0);
        wr(ID_M, 6'd11, 32'h0);
        wr(ID_M, 6'd5, 32'h0);
        wr(ID_M, 6'd7, 32'hFFFF_FFFF);
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        logic [31:0] dm, ds;
        reset = 1'b1; reg_access = 1'b0; reg_packet = '0; gpio_in = '0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        m_odata = '0;
        total++;
        if ({gpio_out_m, gpio_en_m, ilat_m, rdata_m, gpio_out_s, rdata_s} !== '0 || irq_m !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got out=%h en=%h ilat=%h rd=%h irq=%b exp all 0",
                     gpio_out_m, gpio_en_m, ilat_m, rdata_m, irq_m);
        end
        rd(ID_M, 6'd13, dm, ds);
        total++;
        if (dm !== 32'h0) begin bad++; $display("FAIL reset_dbdiv got=%h exp=0", dm); end
    endtask

    task automatic test_odata();
        logic [31:0] dm, ds, d, exp_v[4];
        logic [5:0]  ops[4];
        exp_v = '{32'hF0, 32'h0F, 32'h0F, 32'h10F};
        ops   = '{6'd0, 6'd10, 6'd8, 6'd9};
        wr(ID_M, ops[0], 32'hF0);
        wr(ID_M, ops[1], 32'hFF);
        wr(ID_M, ops[2], 32'h0F);
        wr(ID_M, ops[3], 32'h100);
        m_odata = exp_v[3];
        total++;
        if (gpio_out_m !== m_odata) begin bad++; $display("FAIL odata_seq got=%h exp=%h", gpio_out_m, m_odata); end
        rd(ID_M, 6'd0, dm, ds);
        total++;
        if (dm !== 32'h10F) begin bad++; $display("FAIL odata_read got=%h exp=10f", dm); end
        rd(ID_M, 6'd40, dm, ds);
        total++;
        if (dm !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", dm); end
        for (int i = 0; i < 10; i++) begin
            int op;
            op = $urandom_range(0, 3);
            d  = $urandom;
            wr(ID_M, ops[op], d);
            case (op)
                0: m_odata = d;
                1: m_odata = m_odata ^ d;
                2: m_odata = m_odata & d;
                default: m_odata = m_odata | d;
            endcase
            total++;
            if (gpio_out_m !== m_odata) begin
                bad++; $display("FAIL odata_rand op=%0d got=%h exp=%h", op, gpio_out_m, m_odata);
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] dm, ds, d, exp_d;
        logic [5:0]  words[8];
        words = '{6'd1, 6'd3, 6'd4, 6'd5, 6'd11, 6'd12, 6'd13, 6'd14};
        for (int i = 0; i < 12; i++) begin
            int k;
            k = $urandom_range(0, 7);
            d = $urandom;
            exp_d = (words[k] == 6'd13) ? (d & 32'hFFFF) :
                    (words[k] == 6'd14) ? (d & 32'hFF) : d;
            wr(ID_M, words[k], d);
            rd(ID_M, words[k], dm, ds);
            total++;
            if (dm !== exp_d) begin bad++; $display("FAIL reg_rw word=%0d got=%h exp=%h", words[k], dm, exp_d); end
        end
        wr(ID_M, 6'd1, 32'h5A5A_1234);
        total++;
        if (gpio_en_m !== 32'h5A5A_1234) begin bad++; $display("FAIL oen_pad got=%h exp=5a5a1234", gpio_en_m); end
        for (int k = 0; k < 8; k++) wr(ID_M, words[k], 32'h0);
    endtask

    task automatic test_idata();
        logic [31:0] dm, ds, v;
        for (int i = 0; i < 5; i++) begin
            v = $urandom;
            gpio_in = v;
            cyc(3);
            rd(ID_M, 6'd2, dm, ds);
            total++;
            if (dm !== v) begin bad++; $display("FAIL idata got=%h exp=%h", dm, v); end
        end
        gpio_in = '0;
        cyc(4);
    endtask

    task automatic test_edge_irq();
        setup_edge();
        wr(ID_M, 6'd5, 32'h1);
        total++;
        if (ilat_m !== 32'h0) begin bad++; $display("FAIL edge_clean got=%h exp=0", ilat_m); end
        gpio_in[0] = 1'b1;
        cyc(3);
        total++;
        if (ilat_m[0] !== 1'b0 || irq_m !== 1'b0) begin
            bad++; $display("FAIL edge_early got ilat=%b irq=%b exp 0 0", ilat_m[0], irq_m);
        end
        cyc(1);
        total++;
        if (ilat_m[0] !== 1'b1 || irq_m !== 1'b1) begin
            bad++; $display("FAIL edge_4edges got ilat=%b irq=%b exp 1 1", ilat_m[0], irq_m);
        end
        wr(ID_M, 6'd7, 32'h1);
        total++;
        if (ilat_m[0] !== 1'b0 || irq_m !== 1'b0) begin
            bad++; $display("FAIL edge_clear got ilat=%b irq=%b exp 0 0", ilat_m[0], irq_m);
        end
        gpio_in[0] = 1'b0;
        cyc(6);
        total++;
        if (ilat_m !== 32'h0) begin bad++; $display("FAIL edge_fall_ignored got=%h exp=0", ilat_m); end
    endtask

    task automatic test_both();
        wr(ID_M, 6'd11, 32'h1);
        gpio_in[0] = 1'b1;
        cyc(4);
        total++;
        if (ilat_m[0] !== 1'b1) begin bad++; $display("FAIL both_rise got=%b exp=1", ilat_m[0]); end
        wr(ID_M, 6'd7, 32'h1);
        total++;
        if (ilat_m[0] !== 1'b0) begin bad++; $display("FAIL both_mid_clear got=%b exp=0", ilat_m[0]); end
        cyc(5);
        gpio_in[0] = 1'b0;
        cyc(3);
        total++;
        if (ilat_m[0] !== 1'b0) begin bad++; $display("FAIL both_fall_early got=%b exp=0", ilat_m[0]); end
        cyc(1);
        total++;
        if (ilat_m[0] !== 1'b1) begin bad++; $display("FAIL both_fall got=%b exp=1", ilat_m[0]); end
        wr(ID_M, 6'd7, 32'hFFFF_FFFF);
        wr(ID_M, 6'd11, 32'h0);
    endtask

    task automatic test_level();
        logic [31:0] dm, ds;
        wr(ID_M, 6'd3, 32'hFFFF_FFFE);
        wr(ID_M, 6'd7, 32'hFFFF_FFFF);
        gpio_in[0] = 1'b1;
        cyc(4);
        total++;
        if (ilat_m[0] !== 1'b1) begin bad++; $display("FAIL level_set got=%b exp=1", ilat_m[0]); end
        wr(ID_M, 6'd7, 32'h1);
        total++;
        if (ilat_m[0] !== 1'b1) begin bad++; $display("FAIL level_clr_while_high got=%b exp=1", ilat_m[0]); end
        wr(ID_M, 6'd4, 32'h1);
        wr(ID_M, 6'd7, 32'h1);
        total++;
        if (ilat_m[0] !== 1'b0) begin bad++; $display("FAIL level_ipol_clear got=%b exp=0", ilat_m[0]); end
        gpio_in[0] = 1'b0;
        cyc(3);
        total++;
        if (ilat_m[0] !== 1'b0) begin bad++; $display("FAIL level_low_early got=%b exp=0", ilat_m[0]); end
        cyc(1);
        total++;
        if (ilat_m[0] !== 1'b1) begin bad++; $display("FAIL level_active_low got=%b exp=1", ilat_m[0]); end
        wr(ID_M, 6'd4, 32'h0);
        wr(ID_M, 6'd7, 32'h1);
        wr(ID_M, 6'd6, 32'h8);
        total++;
        if (ilat_m !== 32'h8) begin bad++; $display("FAIL ilat_w1s got=%h exp=8", ilat_m); end
        rd(ID_M, 6'd7, dm, ds);
        total++;
        if (dm !== 32'h8) begin bad++; $display("FAIL ilatclr_read got=%h exp=8", dm); end
        wr(ID_M, 6'd7, 32'h8);
        // Edge event landing on the same edge as the clear write.
        wr(ID_M, 6'd3, 32'hFFFF_FFFF);
        gpio_in[0] = 1'b1;
        cyc(3);
        wr(ID_M, 6'd7, 32'h1);
        total++;
        if (ilat_m !== 32'h1) begin bad++; $display("FAIL set_beats_clear got=%h exp=1", ilat_m); end
        gpio_in[0] = 1'b0;
        cyc(5);
        wr(ID_M, 6'd7, 32'hFFFF_FFFF);
    endtask

    task automatic test_debounce();
        logic [31:0] dm, ds;
        int seen, n, lo, hi;
        int div, thr;
        div = 3; thr = 4;
        setup_edge();
        wr(ID_M, 6'd13, 32'(div));
        wr(ID_M, 6'd14, 32'(thr));
        wr(ID_M, 6'd12, 32'h1);
        seen = 0;
        gpio_in[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin cyc(1); if (ilat_m[0]) seen++; end
        gpio_in[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin cyc(1); if (ilat_m[0]) seen++; end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL db_glitch_ilat got=%0d exp=0", seen); end
        rd(ID_M, 6'd2, dm, ds);
        total++;
        if (dm[0] !== 1'b0) begin bad++; $display("FAIL db_glitch_idata got=%b exp=0", dm[0]); end
        // Stable input: thr ticks after sync, first tick within div+1 cycles.
        lo = 4 + (thr - 1) * (div + 1);
        hi = lo + div;
        gpio_in[0] = 1'b1;
        n = 0;
        while (ilat_m[0] !== 1'b1 && n < 40) begin cyc(1); n++; end
        total++;
        if (n < lo || n > hi) begin bad++; $display("FAIL db_stable_latency got=%0d exp=%0d..%0d", n, lo, hi); end
        rd(ID_M, 6'd2, dm, ds);
        total++;
        if (dm[0] !== 1'b1) begin bad++; $display("FAIL db_stable_idata got=%b exp=1", dm[0]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] dm, ds;
        wr(ID_M, 6'd5, 32'hFFFF_FFFF);
        wr(ID_M, 6'd6, 32'h5);
        gpio_in[0] = 1'b0;
        cyc(6);
        gpio_in[0] = 1'b1;
        reset = 1'b1;
        cyc(1);
        m_odata = '0;
        total++;
        if ({gpio_out_m, gpio_en_m, ilat_m, rdata_m} !== '0 || irq_m !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs got out=%h ilat=%h rd=%h irq=%b exp 0",
                            gpio_out_m, ilat_m, rdata_m, irq_m);
        end
        reset = 1'b0;
        cyc(3);
        total++;
        if (ilat_m !== 32'h0) begin bad++; $display("FAIL midreset_no_stale got=%h exp=0", ilat_m); end
        cyc(1);
        total++;
        if (ilat_m !== 32'h1 || irq_m !== 1'b0) begin
            bad++; $display("FAIL midreset_held_high got ilat=%h irq=%b exp 1 0", ilat_m, irq_m);
        end
        rd(ID_M, 6'd12, dm, ds);
        total++;
        if (dm !== 32'h0) begin bad++; $display("FAIL midreset_dben got=%h exp=0", dm); end
    endtask

    task automatic test_narrow();
        logic [31:0] dm, ds;
        wr(ID_S, 6'd0, 32'hFFFF_FFFF);
        total++;
        if (gpio_out_s !== 8'hFF || gpio_out_m !== m_odata) begin
            bad++; $display("FAIL narrow_out got s=%h m=%h exp ff %h", gpio_out_s, gpio_out_m, m_odata);
        end
        rd(ID_S, 6'd0, dm, ds);
        total++;
        if (ds !== 32'h0000_00FF) begin bad++; $display("FAIL narrow_read got=%h exp=000000ff", ds); end
        wr(ID_S, 6'd1, 32'hABCD_EF12);
        rd(ID_S, 6'd1, dm, ds);
        total++;
        if (ds !== 32'h12 || gpio_en_s !== 8'h12) begin
            bad++; $display("FAIL narrow_oen got rd=%h pad=%h exp 12", ds, gpio_en_s);
        end
        wr(ID_S, 6'd20, 32'hFFFF_FFFF);
        rd(ID_S, 6'd15, dm, ds);
        total++;
        if (ds !== 32'h0) begin bad++; $display("FAIL narrow_unmapped got=%h exp=0", ds); end
        rd(ID_S, 6'd1, dm, ds);
        total++;
        if (ds !== 32'h12) begin bad++; $display("FAIL narrow_drop_write got=%h exp=12", ds); end
    endtask

    task automatic test_wrong_id();
        wr(3'd5, 6'd0, 32'h1234_5678);
        total++;
        if (gpio_out_m !== m_odata || gpio_out_s !== 8'hFF) begin
            bad++; $display("FAIL wrong_id got m=%h s=%h exp %h ff", gpio_out_m, gpio_out_s, m_odata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_odata();
        test_regs();
        test_idata();
        test_edge_irq();
        test_both();
        test_level();
        test_debounce();
        test_reset_mid();
        test_narrow();
        test_wrong_id();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
